// File: rtl/note_recorder_if.sv
// ---------------------------------------------------------------------------
// note_recorder_if
// Groups the audio-in FIFO handshake and the sample-RAM write port used by
// note_recorder.
//   audio_in_available     FIFO holds a sample (head valid while high)
//   left_channel_audio_in  signed 32-bit head-of-FIFO sample
//   read_audio_in          pops the FIFO
//   ram_address            RAM write address (DEPTH_LOG2 bits)
//   ram_data               RAM write data (SAMPLE_W bits)
//   ram_wren               RAM write enable, one cycle per sample
// The master modport is the recorder; the slave modport is the FIFO/RAM side.
// ---------------------------------------------------------------------------
interface note_recorder_if #(
  parameter int DEPTH_LOG2 = 14,
  parameter int SAMPLE_W   = 10
);
  logic                  audio_in_available;
  logic [31:0]           left_channel_audio_in;
  logic                  read_audio_in;
  logic [DEPTH_LOG2-1:0] ram_address;
  logic [SAMPLE_W-1:0]   ram_data;
  logic                  ram_wren;

  modport master (
    input  audio_in_available,
    input  left_channel_audio_in,
    output read_audio_in,
    output ram_address,
    output ram_data,
    output ram_wren
  );

  modport slave (
    output audio_in_available,
    output left_channel_audio_in,
    input  read_audio_in,
    input  ram_address,
    input  ram_data,
    input  ram_wren
  );
endinterface

// File: rtl/note_recorder.sv
// ---------------------------------------------------------------------------
// note_recorder
// Captures a microphone note into a 2^DEPTH_LOG2 x SAMPLE_W sample RAM in the
// same format the note ROMs use. The audio-in FIFO is drained continuously;
// once armed, the first sample whose magnitude strictly exceeds
// TRIGGER_LEVEL starts a capture of 2^DEPTH_LOG2 consecutive samples.
// Ports:
//   CLOCK_50  system clock
//   reset     asynchronous, active-high reset
//   start     single-cycle request that arms a capture (IDLE/DONE only)
//   abort     cancels any capture and returns to IDLE (highest priority)
//   bus       FIFO handshake + RAM write port (note_recorder_if.master)
//   busy      high while armed or recording
//   done      high once a full capture has been written
//   peak      largest recorded magnitude (top SAMPLE_W bits), unsigned
// ---------------------------------------------------------------------------
module note_recorder #(
  parameter int          DEPTH_LOG2    = 14,
  parameter int          SAMPLE_W      = 10,
  parameter logic [31:0] TRIGGER_LEVEL = 32'h001FFF00
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  note_recorder_if.master     bus,
  output logic                busy,
  output logic                done,
  output logic [SAMPLE_W-1:0] peak
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_RECORD = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Absolute value; the most negative input maps onto itself (32'h80000000),
  // which as an unsigned number is above any trigger level.
  function automatic logic [31:0] f_mag(input logic signed [31:0] s);
    return s[31] ? $unsigned(-s) : $unsigned(s);
  endfunction

  function automatic logic [SAMPLE_W-1:0] f_peak_max(
    input logic [SAMPLE_W-1:0] cur,
    input logic [SAMPLE_W-1:0] cand
  );
    return (cand > cur) ? cand : cur;
  endfunction

  state_t                r_state;
  logic [DEPTH_LOG2-1:0] r_cnt;
  logic [DEPTH_LOG2-1:0] r_addr;
  logic [SAMPLE_W-1:0]   r_data;
  logic                  r_wren;
  logic                  r_busy;
  logic                  r_done;
  logic [SAMPLE_W-1:0]   r_peak;

  logic signed [31:0]    w_in;
  logic [31:0]           w_mag;
  logic [SAMPLE_W-1:0]   w_sample;
  logic [SAMPLE_W-1:0]   w_cand;
  logic                  w_consume;
  logic                  w_trig;
  logic [DEPTH_LOG2-1:0] w_cnt_one;

  assign w_in      = bus.left_channel_audio_in;
  assign w_mag     = f_mag(w_in);
  assign w_sample  = w_in[31 -: SAMPLE_W];
  assign w_cand    = w_mag[31 -: SAMPLE_W];
  assign w_trig    = (w_mag > TRIGGER_LEVEL);
  assign w_cnt_one = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  // The FIFO is popped whenever it has data so it never backs up; samples
  // that arrive while idle or below the trigger are simply discarded.
  assign bus.read_audio_in = bus.audio_in_available & ~reset;
  assign w_consume         = bus.audio_in_available;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_wren  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_peak  <= '0;
    end else begin
      r_wren <= 1'b0;
      if (abort) begin
        // Address/data keep their last values; peak is preserved.
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_busy  <= 1'b0;
        r_done  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_state <= S_ARMED;
              r_peak  <= '0;
              r_busy  <= 1'b1;
            end
          end
          S_ARMED: begin
            if (w_consume && w_trig) begin
              r_state <= S_RECORD;
              r_addr  <= '0;
              r_data  <= w_sample;
              r_wren  <= 1'b1;
              r_cnt   <= w_cnt_one;
              r_peak  <= f_peak_max(r_peak, w_cand);
            end
          end
          S_RECORD: begin
            if (w_consume) begin
              r_addr <= r_cnt;
              r_data <= w_sample;
              r_wren <= 1'b1;
              r_peak <= f_peak_max(r_peak, w_cand);
              // Counter wraps to 0 on the top-address write.
              r_cnt  <= r_cnt + 1'b1;
              if (r_cnt == '1) begin
                r_state <= S_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end
          end
          S_DONE: begin
            if (start) begin
              r_state <= S_ARMED;
              r_peak  <= '0;
              r_done  <= 1'b0;
              r_busy  <= 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.ram_address = r_addr;
  assign bus.ram_data    = r_data;
  assign bus.ram_wren    = r_wren;
  assign busy            = r_busy;
  assign done            = r_done;
  assign peak            = r_peak;

endmodule

// File: tb/tb_note_recorder.sv
// ---------------------------------------------------------------------------
// tb_note_recorder
// Self-checking bench for note_recorder. A behavioural model (armed flag +
// count of samples written) predicts every output each cycle; directed
// scenarios add literal expectations, followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_note_recorder;
  localparam int          DL   = 14;
  localparam int          SW   = 10;
  localparam int          NS   = 1 << DL;
  localparam logic [31:0] TRIG = 32'h001FFF00;

  logic          CLOCK_50 = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic          busy;
  logic          done;
  logic [SW-1:0] peak;

  note_recorder_if #(.DEPTH_LOG2(DL), .SAMPLE_W(SW)) ifc ();

  note_recorder #(.DEPTH_LOG2(DL), .SAMPLE_W(SW), .TRIGGER_LEVEL(TRIG)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .bus      (ifc),
    .busy     (busy),
    .done     (done),
    .peak     (peak)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: "busy" means a capture is pending; m_n counts the
  // samples already written in the current capture (0 = still waiting for
  // a trigger).
  bit            m_busy, m_done, m_wren;
  int            m_n;
  logic [SW-1:0] m_peak, m_data;
  logic [DL-1:0] m_addr;

  always @(posedge CLOCK_50) begin
    logic [31:0] d, mg;
    if (reset) begin
      m_busy = 0; m_done = 0; m_wren = 0; m_n = 0;
      m_peak = '0; m_data = '0; m_addr = '0;
    end else begin
      d      = ifc.left_channel_audio_in;
      mg     = d[31] ? (32'd0 - d) : d;
      m_wren = 0;
      if (abort) begin
        m_busy = 0; m_done = 0; m_n = 0;
      end else if (!m_busy) begin
        if (start) begin
          m_busy = 1; m_done = 0; m_peak = '0; m_n = 0;
        end
      end else if (ifc.audio_in_available && (m_n > 0 || mg > TRIG)) begin
        m_wren = 1;
        m_addr = m_n[DL-1:0];
        m_data = d[31 -: SW];
        if (mg[31 -: SW] > m_peak) m_peak = mg[31 -: SW];
        m_n++;
        if (m_n == NS) begin
          m_busy = 0; m_done = 1; m_n = 0;
        end
      end
    end
    #1;
    chk("read_audio_in", {31'd0, ifc.read_audio_in}, {31'd0, (!reset && ifc.audio_in_available)});
    chk("ram_wren", {31'd0, ifc.ram_wren}, {31'd0, m_wren});
    chk("ram_address", {18'd0, ifc.ram_address}, {18'd0, m_addr});
    chk("ram_data", {22'd0, ifc.ram_data}, {22'd0, m_data});
    chk("busy", {31'd0, busy}, {31'd0, m_busy});
    chk("done", {31'd0, done}, {31'd0, m_done});
    chk("peak", {22'd0, peak}, {22'd0, m_peak});
  end

  // Sets inputs for the next rising edge.
  task automatic cyc(input bit s, input bit a, input bit av, input logic [31:0] d);
    @(negedge CLOCK_50);
    start = s;
    abort = a;
    ifc.audio_in_available    = av;
    ifc.left_channel_audio_in = d;
  endtask

  // Waits past the next edge and past the model's compare point.
  task automatic settle();
    @(posedge CLOCK_50);
    #2;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    ifc.audio_in_available    = 1'b1;
    ifc.left_channel_audio_in = 32'h7FFFFFFF;

    // Reset held 3 cycles with data available
    repeat (3) @(posedge CLOCK_50);
    #2;
    chk("rst_read", {31'd0, ifc.read_audio_in}, 32'd0);
    chk("rst_wren", {31'd0, ifc.ram_wren}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_peak", {22'd0, peak}, 32'd0);
    @(negedge CLOCK_50);
    reset = 1'b0;
    #1;
    chk("read_follows_1", {31'd0, ifc.read_audio_in}, 32'd1);
    ifc.audio_in_available = 1'b0;
    #1;
    chk("read_follows_0", {31'd0, ifc.read_audio_in}, 32'd0);

    // Trigger threshold
    cyc(1, 0, 0, 32'h0);
    cyc(0, 0, 1, 32'h001FFF00);
    settle();
    chk("thr_eq_drop", {31'd0, ifc.ram_wren}, 32'd0);
    chk("thr_armed_busy", {31'd0, busy}, 32'd1);
    cyc(0, 0, 1, 32'hFFE00100);
    settle();
    chk("thr_neg_eq_drop", {31'd0, ifc.ram_wren}, 32'd0);
    cyc(0, 0, 1, 32'h001FFF01);
    settle();
    chk("thr_trig_wren", {31'd0, ifc.ram_wren}, 32'd1);
    chk("thr_trig_addr", {18'd0, ifc.ram_address}, 32'd0);
    chk("thr_trig_data", {22'd0, ifc.ram_data}, 32'h000);
    cyc(0, 1, 0, 32'h0);
    cyc(0, 0, 0, 32'h0);

    // Full capture
    cyc(1, 0, 0, 32'h0);
    cyc(0, 0, 1, 32'h7FC00000);
    settle();
    chk("full_first_data", {22'd0, ifc.ram_data}, 32'h1FF);
    for (int i = 1; i < NS; i++) cyc(0, 0, 1, 32'hC0000000);
    settle();
    chk("full_last_addr", {18'd0, ifc.ram_address}, 32'h3FFF);
    chk("full_last_data", {22'd0, ifc.ram_data}, 32'h300);
    chk("full_done", {31'd0, done}, 32'd1);
    chk("full_busy", {31'd0, busy}, 32'd0);
    chk("full_peak", {22'd0, peak}, 32'h1FF);
    cyc(0, 0, 1, 32'hC0000000);
    settle();
    chk("full_no_extra", {31'd0, ifc.ram_wren}, 32'd0);
    chk("full_done_hold", {31'd0, done}, 32'd1);

    // Gapped input, 1-of-3 duty
    cyc(1, 0, 0, 32'h0);
    cyc(0, 0, 1, 32'h40000000);
    for (int i = 0; i < 300; i++) cyc(0, 0, (i % 3) == 0, $urandom);
    settle();
    chk("gap_addr", {18'd0, ifc.ram_address}, 32'd100);
    cyc(0, 1, 0, 32'h0);

    // Abort + start collision at address 100, then re-arm with -full-scale
    cyc(1, 0, 0, 32'h0);
    cyc(0, 0, 1, 32'h7FC00000);
    for (int i = 1; i <= 100; i++) cyc(0, 0, 1, $urandom);
    settle();
    chk("coll_addr", {18'd0, ifc.ram_address}, 32'd100);
    cyc(1, 1, 1, 32'h7FC00000);
    settle();
    chk("coll_wren", {31'd0, ifc.ram_wren}, 32'd0);
    chk("coll_busy", {31'd0, busy}, 32'd0);
    chk("coll_done", {31'd0, done}, 32'd0);
    chk("coll_peak_hold", {22'd0, peak}, 32'h1FF);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 32'h7FC00000);
    cyc(1, 0, 0, 32'h0);
    settle();
    chk("rearm_busy", {31'd0, busy}, 32'd1);
    chk("rearm_peak_clr", {22'd0, peak}, 32'd0);
    cyc(0, 0, 1, 32'h80000000);
    settle();
    chk("negx_wren", {31'd0, ifc.ram_wren}, 32'd1);
    chk("negx_addr", {18'd0, ifc.ram_address}, 32'd0);
    chk("negx_data", {22'd0, ifc.ram_data}, 32'h200);
    chk("negx_peak", {22'd0, peak}, 32'h200);

    // Asynchronous reset mid-capture
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, $urandom);
    @(negedge CLOCK_50);
    #2;
    reset = 1'b1;
    #1;
    chk("areset_wren", {31'd0, ifc.ram_wren}, 32'd0);
    chk("areset_busy", {31'd0, busy}, 32'd0);
    chk("areset_peak", {22'd0, peak}, 32'd0);
    chk("areset_read", {31'd0, ifc.read_audio_in}, 32'd0);
    repeat (2) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    reset = 1'b0;

    // Randomized phase
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] d;
      d = ($urandom_range(3) == 0) ? ($urandom_range(32'h00400000) - 32'h00200000) : $urandom;
      cyc($urandom_range(15) == 0, $urandom_range(63) == 0, $urandom_range(1) == 1, d);
    end

    cyc(0, 0, 0, 32'h0);
    repeat (2) @(posedge CLOCK_50);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/note_recorder.md
# note_recorder

Records a microphone note into a 16384 x 10 sample RAM in the same format the note ROMs use, so a player can capture a reference tone and later play it back through the existing note path. It is the consumer of the Audio_Controller audio-in FIFO: it drains `left_channel_audio_in` through the `audio_in_available` / `read_audio_in` handshake. It waits, armed, for a sample above a trigger level, then writes 2^DEPTH_LOG2 consecutive samples to the RAM write port.

## Interface
- DEPTH_LOG2, 14, RAM address width; one capture is 2^DEPTH_LOG2 samples.
- SAMPLE_W, 10, stored sample width; always the top SAMPLE_W bits of the 32-bit input.
- TRIGGER_LEVEL, 32'h001FFF00, magnitude that must be strictly exceeded to start a capture.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request that arms a capture.
- abort  in  1  cancels any capture and returns to IDLE.
- audio_in_available  in  1  audio-in FIFO holds a sample.
- left_channel_audio_in  in  32  signed head-of-FIFO sample, valid while audio_in_available is high.
- read_audio_in  out  1  pops the FIFO.
- ram_address  out  DEPTH_LOG2  RAM write address.
- ram_data  out  SAMPLE_W  RAM write data.
- ram_wren  out  1  RAM write enable, one cycle per sample.
- busy  out  1  high in ARMED and RECORD.
- done  out  1  high in DONE.
- peak  out  SAMPLE_W  largest recorded magnitude, unsigned.

## Operation
- A sample is consumed on any rising edge where `read_audio_in` and `audio_in_available` are both 1.
- `read_audio_in` = `audio_in_available` (combinational) in every state, so the FIFO never backs up. It is forced to 0 while `reset` is high.
- Magnitude: `mag` = `in[31] ? -in : in`, 32-bit unsigned. The value 32'h80000000 stays 32'h80000000 and counts as above any trigger.
- Stored data: `in[31:32-SAMPLE_W]`, two's complement, unchanged. Playback reconstructs the sample as {data, 22'b0}.
- Peak candidate: `mag[31:32-SAMPLE_W]`.

States are IDLE, ARMED, RECORD and DONE. `abort` has priority over every other transition.
- **IDLE:** `start` moves to ARMED and clears `peak` to 0.
- **ARMED:** on a consumed sample with `mag` > TRIGGER_LEVEL:
  - the state moves to RECORD;
  - that sample is written at address 0;
  - the address counter becomes 1.
  - Samples at or below TRIGGER_LEVEL are dropped.
- **RECORD:** every consumed sample is written at the counter value, and the counter increments.
  - The write at address 2^DEPTH_LOG2-1 moves the state to DONE and wraps the counter to 0.
  - Nothing is ever written past the top address.
- **DONE:** holds until `start`, which moves to ARMED, clears `peak` and clears `done`. The RAM content is kept until overwritten.
- `start` in ARMED or RECORD is ignored.
- `abort` in any state:
  - moves to IDLE and clears the counter;
  - drives `ram_wren` to 0 on the next cycle;
  - leaves `done` at 0 and `peak` holding its value.
- `abort` and `start` in the same cycle: `abort` wins.
- `peak` updates to max(`peak`, candidate) on every write, including the trigger sample.

## Timing
- Reset values:
  - state IDLE and counter 0;
  - `ram_address` 0, `ram_data` 0, `ram_wren` 0;
  - `busy` 0, `done` 0, `peak` 0.
- Reset asserted mid-capture aborts it immediately (asynchronous). No further writes occur.
- `ram_address`, `ram_data` and `ram_wren` are registered.
  - For a write caused by a sample consumed at edge N, all three are valid from edge N until edge N+1.
  - `ram_wren` is 1 for exactly that one cycle.
  - `ram_address` and `ram_data` hold their last values when `ram_wren` is 0.
- `busy`, `done` and `peak` are registered and change at the same edge as the state transition.
- `done` rises at the same edge that issues the final write (address 2^DEPTH_LOG2-1). `busy` falls at that edge.
- Back-to-back consumption (`audio_in_available` high on consecutive cycles) produces a write on every cycle. There is no throughput limit.
- Latency: trigger sample to its RAM write is 1 cycle; `start` to ARMED is 1 cycle.

## Test plan
- **Reset:** hold `reset` high for 3 cycles with `audio_in_available`=1. Required: `read_audio_in`=0, all outputs 0. After release, `read_audio_in` follows `audio_in_available`.
- **Trigger threshold:** pulse `start`, then feed 32'h001FFF00, 32'hFFE00100 (magnitude 32'h001FFF00) and 32'h001FFF01.
  - The first two are dropped with `ram_wren`=0.
  - The third gives `ram_wren`=1, `ram_address`=0, `ram_data`=10'h000.
- **Full capture:** trigger with 32'h7FC00000, then 16383 samples of 32'hC0000000 on consecutive cycles.
  - Required: writes at addresses 0..16383 with data 10'h1FF, then 10'h300.
  - `done` rises at the last write, `busy` falls, and no write occurs at a 16385th sample.
  - `peak`=10'h1FF at the end.
- **Gapped input:** in RECORD, toggle `audio_in_available` with 1-of-3 duty. Required: one write per consumed sample, consecutive addresses, no skipped or duplicated addresses.
- **Abort and start collision:** assert `abort` and `start` in the same cycle at address 100 in RECORD. Required: state IDLE next cycle, `busy`=0, `done`=0, no further writes; a later `start` re-arms.
- **Negative extreme:** trigger with 32'h80000000. Required: capture starts, `ram_data`=10'h200, `peak`=10'h200.
